// File: rtl/reverb_allpass_mix.sv
// reverb_allpass_mix
// Output stage of the Schroeder reverb path. One allpass diffuser backed by
// a circular delay RAM, then a dry/wet Q1.15 mix saturated to 16 bits.
//
// Handshake: in_valid is a one-cycle strobe. It is accepted only in a cycle
// where ready is high (state IDLE). A strobe seen while ready is low is
// dropped and sets the sticky overrun flag; the sample in flight is not
// disturbed. out_valid is a one-cycle pulse; dout holds until the next pulse.
//
// Pipeline for one accepted sample (edge E0 = acceptance edge):
//   E0 IDLE  : register din/dry_in, issue RAM read of RAM[ptr]
//   E1 READ  : capture RAM data into tap_q
//   E2 CALC1 : v = sat16(x + ((g*tap) >>> 15))
//   E3 CALC2 : RAM[ptr] <= v, y = sat16(tap - ((g*v) >>> 15)), ptr advance
//   E4 MIX   : dout = sat16((dry_gain*dry + wet_gain*y) >>> 15), out_valid
// The FSM state is exported on fsm_state for observation.

module reverb_allpass_mix #(
  parameter int                 DELAY    = 1116,
  parameter logic signed [15:0] GAIN     = 16'sd16384,
  parameter logic signed [15:0] DRY_GAIN = 16'sd16384,
  parameter logic signed [15:0] WET_GAIN = 16'sd16384
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] din,
  input  logic signed [15:0] dry_in,
  input  logic               in_valid,
  output logic               ready,
  output logic signed [15:0] dout,
  output logic               out_valid,
  output logic               overrun,
  output logic [2:0]         fsm_state
);

  // Pointer width; DELAY is at least 2 so this is at least 1 bit.
  localparam int AW = $clog2(DELAY);
  localparam logic [AW-1:0] PTR_LAST = AW'(DELAY - 1);

  // Coefficients widened once so every product is a plain 32-bit signed multiply.
  localparam logic signed [31:0] GAIN_W = 32'(GAIN);
  localparam logic signed [31:0] DRY_W  = 32'(DRY_GAIN);
  localparam logic signed [31:0] WET_W  = 32'(WET_GAIN);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_CALC1 = 3'd3,
    S_CALC2 = 3'd4,
    S_MIX   = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // Pointer doubles as the clear address, so CLEAR ends with ptr back at 0.
  logic [AW-1:0] ptr;

  // Delay RAM and its synchronous read port.
  logic signed [15:0] ram [DELAY];
  logic signed [15:0] rd_data;
  logic               ram_we;
  logic               ram_re;
  logic signed [15:0] ram_wdata;

  // FSM output decodes.
  logic accept;
  logic ptr_step;

  // Sample pipeline registers.
  logic signed [15:0] x_q;
  logic signed [15:0] dry_q;
  logic signed [15:0] tap_q;
  logic signed [15:0] v_q;
  logic signed [15:0] y_q;

  // Combinational datapath.
  logic signed [31:0] p_tap;
  logic signed [31:0] p_tap_sh;
  logic signed [16:0] sum_v;
  logic signed [15:0] v_calc;
  logic signed [31:0] p_v;
  logic signed [31:0] p_v_sh;
  logic signed [16:0] sum_y;
  logic signed [15:0] y_calc;
  logic signed [31:0] p_dry;
  logic signed [31:0] p_wet;
  logic signed [32:0] sum_mix;
  logic signed [32:0] mix_sh;
  logic signed [15:0] mix_calc;

  // Clamp a wide signed value into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [32:0] a);
    if (a > 33'sd32767) begin
      return 16'sh7fff;
    end else if (a < -33'sd32768) begin
      return 16'sh8000;
    end else begin
      return a[15:0];
    end
  endfunction

  // State register; reset always restarts the RAM clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (ptr == PTR_LAST) state_next = S_IDLE;
      S_IDLE:  if (in_valid) state_next = S_READ;
      S_READ:  state_next = S_CALC1;
      S_CALC1: state_next = S_CALC2;
      S_CALC2: state_next = S_MIX;
      S_MIX:   state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
  end

  // FSM output decodes: handshake, RAM port control, pointer stepping.
  always_comb begin
    ready     = 1'b0;
    accept    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_wdata = 16'sd0;
    ptr_step  = 1'b0;
    case (state)
      S_CLEAR: begin
        ram_we   = ~reset;
        ptr_step = 1'b1;
      end
      S_IDLE: begin
        ready  = 1'b1;
        accept = in_valid;
        ram_re = in_valid;
      end
      S_CALC2: begin
        ram_we    = ~reset;
        ram_wdata = v_q;
        ptr_step  = 1'b1;
      end
      default: ;
    endcase
  end

  assign fsm_state = state;

  // Circular pointer, wrapping to 0 after DELAY-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (ptr_step) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
    end
  end

  // Delay RAM: single address (ptr), synchronous write and read.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ptr] <= ram_wdata;
    end
    if (ram_re) begin
      rd_data <= ram[ptr];
    end
  end

  // Allpass and mix arithmetic; products 32-bit, allpass sums 17-bit, mix 33-bit.
  always_comb begin
    p_tap    = GAIN_W * 32'(tap_q);
    p_tap_sh = p_tap >>> 15;
    sum_v    = 17'(x_q) + $signed(p_tap_sh[16:0]);
    v_calc   = sat16(33'(sum_v));

    p_v      = GAIN_W * 32'(v_q);
    p_v_sh   = p_v >>> 15;
    sum_y    = 17'(tap_q) - $signed(p_v_sh[16:0]);
    y_calc   = sat16(33'(sum_y));

    p_dry    = DRY_W * 32'(dry_q);
    p_wet    = WET_W * 32'(y_q);
    sum_mix  = 33'(p_dry) + 33'(p_wet);
    mix_sh   = sum_mix >>> 15;
    mix_calc = sat16(mix_sh);
  end

  // Sample pipeline registers, advanced by the FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      dry_q <= '0;
      tap_q <= '0;
      v_q   <= '0;
      y_q   <= '0;
    end else begin
      if (accept) begin
        x_q   <= din;
        dry_q <= dry_in;
      end
      if (state == S_READ) begin
        tap_q <= rd_data;
      end
      if (state == S_CALC1) begin
        v_q <= v_calc;
      end
      if (state == S_CALC2) begin
        y_q <= y_calc;
      end
    end
  end

  // Result register and one-cycle out_valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == S_MIX);
      if (state == S_MIX) begin
        dout <= mix_calc;
      end
    end
  end

  // Sticky overrun: any strobe that arrives while not ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (in_valid && (state != S_IDLE)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reverb_allpass_mix.sv
// Bench for reverb_allpass_mix. Two instances share the stimulus:
//   dut_a: DELAY=4, GAIN=16384, DRY_GAIN=0,     WET_GAIN=32767 (impulse/wrap)
//   dut_b: DELAY=4, GAIN=32767, DRY_GAIN=32767, WET_GAIN=32767 (saturation)

module tb_reverb_allpass_mix;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic signed [15:0] din = '0;
  logic signed [15:0] dry_in = '0;
  logic               in_valid = 1'b0;

  logic               ready_a, out_valid_a, overrun_a;
  logic signed [15:0] dout_a;
  logic [2:0]         fsm_state_a;
  logic               ready_b, out_valid_b, overrun_b;
  logic signed [15:0] dout_b;
  logic [2:0]         fsm_state_b;

  reverb_allpass_mix #(
    .DELAY(4), .GAIN(16'sd16384), .DRY_GAIN(16'sd0), .WET_GAIN(16'sd32767)
  ) dut_a (
    .clk(clk), .reset(reset), .din(din), .dry_in(dry_in), .in_valid(in_valid),
    .ready(ready_a), .dout(dout_a), .out_valid(out_valid_a), .overrun(overrun_a),
    .fsm_state(fsm_state_a)
  );

  reverb_allpass_mix #(
    .DELAY(4), .GAIN(16'sd32767), .DRY_GAIN(16'sd32767), .WET_GAIN(16'sd32767)
  ) dut_b (
    .clk(clk), .reset(reset), .din(din), .dry_in(dry_in), .in_valid(in_valid),
    .ready(ready_b), .dout(dout_b), .out_valid(out_valid_b), .overrun(overrun_b),
    .fsm_state(fsm_state_b)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int pulses_a = 0;
  logic [15:0] exp_q[$];

  // Running count of out_valid pulses from dut_a, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid_a) pulses_a <= pulses_a + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- golden model for dut_a ----------------
  int mdl_mem[4];
  int mdl_ptr;

  function automatic int sat(input int a);
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdl_mem[i] = 0;
    mdl_ptr = 0;
  endtask

  task automatic model_step(input int x, input int dr, output int res);
    int tap, v, y;
    longint m;
    tap = mdl_mem[mdl_ptr];
    v = sat(x + ((16384 * tap) >>> 15));
    y = sat(tap - ((16384 * v) >>> 15));
    mdl_mem[mdl_ptr] = v;
    mdl_ptr = (mdl_ptr + 1) % 4;
    m = longint'(0) * dr + longint'(32767) * y;
    res = sat(int'(m >>> 15));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!ready_a && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!ready_a) check("ready_timeout", 0, 1);
  endtask

  // Send one sample; returns the number of edges from acceptance to out_valid.
  task automatic send(input logic signed [15:0] d, input logic signed [15:0] dr,
                      output int lat);
    wait_ready();
    din = d;
    dry_in = dr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pulse_width", int'(out_valid_a), 0);
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (out_valid_a) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic score(input string name);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check(name, int'(dout_a), int'($signed(e)));
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic signed [15:0] din;
    logic signed [15:0] dry;
    int                 exp_a;
  } vec_t;

  vec_t imp[5];
  int   wrap_din[9];
  int   wrap_dry[9];

  task automatic run_impulse(input string tag);
    int lat;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(16'(imp[i].exp_a));
      send(imp[i].din, imp[i].dry, lat);
      check($sformatf("%s_lat[%0d]", tag, i), lat, 4);
      score($sformatf("%s_dout[%0d]", tag, i));
      if (i == 0) check($sformatf("%s_ready_at_out", tag), int'(ready_a), 1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, n, bad, base, res;

    imp[0] = '{16'sd16384, 16'sd1000,  -8192};
    imp[1] = '{16'sd0,     -16'sd500,  0};
    imp[2] = '{16'sd0,     16'sd7,     0};
    imp[3] = '{16'sd0,     16'sd0,     0};
    imp[4] = '{16'sd0,     16'sd3000,  12287};
    wrap_din = '{1000, -2000, 3000, 4000, 5000, -6000, 7000, 8000, 9000};
    wrap_dry = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

    // Reset and clear: ready low for DELAY cycles, outputs quiet.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", int'(ready_a), 0);
    check("rst_dout", int'(dout_a), 0);
    check("rst_out_valid", int'(out_valid_a), 0);
    check("rst_overrun", int'(overrun_a), 0);
    check("rst_state_clear", int'(fsm_state_b), 0);
    n = 0;
    bad = 0;
    while (!ready_a && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (dout_a != 0 || out_valid_a || overrun_a) bad = 1;
    end
    check("clear_cycles", n, 4);
    check("clear_quiet", bad, 0);

    // Impulse response through the allpass.
    run_impulse("impulse");

    // Saturation on dut_b, positive then negative.
    do_reset();
    send(16'sh8000, 16'sh7fff, lat);
    check("sat_pos_lat", lat, 4);
    check("sat_pos", int'(dout_b), 32767);
    send(16'sh7fff, 16'sh8000, lat);
    check("sat_neg", int'(dout_b), -32768);

    // Overrun: strobe at E0, second strobe at E2 is dropped.
    do_reset();
    wait_ready();
    base = pulses_a;
    din = 16'sd16384; dry_in = 16'sd0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    din = 16'sd5000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("ovr_pulses", pulses_a - base, 1);
    check("ovr_dout", int'(dout_a), -8192);
    check("ovr_flag", int'(overrun_a), 1);
    send(16'sd0, 16'sd0, lat);
    check("ovr_next_lat", lat, 4);
    check("ovr_next_dout", int'(dout_a), 0);
    check("ovr_sticky", int'(overrun_a), 1);

    // Pointer wrap over 9 samples against the model.
    do_reset();
    check("ovr_cleared", int'(overrun_a), 0);
    model_reset();
    for (int i = 0; i < 9; i++) begin
      model_step(wrap_din[i], wrap_dry[i], res);
      exp_q.push_back(16'(res));
      send(16'(wrap_din[i]), 16'(wrap_dry[i]), lat);
      score($sformatf("wrap_dout[%0d]", i));
    end

    // Mid-sample reset in CALC1, then strobe during CLEAR.
    do_reset();
    wait_ready();
    din = 16'sd16384; dry_in = 16'sd0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_state_calc1", int'(fsm_state_a), 3);
    base = pulses_a;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("mid_ready_low", int'(ready_a), 0);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    n = 1;
    while (!ready_a && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_clear_cycles", n, 4);
    check("mid_no_out_valid", pulses_a - base, 0);
    check("clear_strobe_overrun", int'(overrun_a), 1);
    run_impulse("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/reverb_allpass_mix.md
# reverb_allpass_mix

Output stage of the Schroeder reverb path. It takes the summed comb-bank output (`Reverb.dout`) and passes it through one Schroeder allpass diffuser backed by a circular delay RAM. It then mixes the diffused wet signal with the original dry sample using Q1.15 gains, saturating to 16 bits. It runs on the fast system clock, accepts one sample per `in_valid` strobe, and emits one result per `out_valid` pulse to the codec output path.

## Interface
- `DELAY`, 1116: allpass delay length in samples; legal range 2..4096.
- `GAIN`, 16'sd16384: allpass coefficient g, signed Q1.15.
- `DRY_GAIN`, 16'sd16384: dry mix gain, signed Q1.15.
- `WET_GAIN`, 16'sd16384: wet mix gain, signed Q1.15.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  16  signed wet input from the comb bank.
- `dry_in`  in  16  signed original (dry) audio sample, time-aligned with `din`.
- `in_valid`  in  1  one-cycle strobe; `din`/`dry_in` valid.
- `ready`  out  1  high when a sample can be accepted (state IDLE).
- `dout`  out  16  signed mixed output, held until the next result.
- `out_valid`  out  1  one-cycle pulse; `dout` updated.
- `overrun`  out  1  sticky; a strobe arrived while `ready` was low.

## Operation
- Delay RAM: `DELAY` x 16 bits, synchronous read. Pointer `ptr` runs 0..DELAY-1 and wraps to 0 after DELAY-1. `buf = RAM[ptr]` holds v from DELAY samples ago.
- Allpass per sample:
  - v = sat16(x + ((GAIN*buf) >>> 15));
  - y = sat16(buf - ((GAIN*v) >>> 15));
  - write v to RAM[ptr], then ptr <= ptr+1 (with wrap).
- Mix: dout = sat16((DRY_GAIN*dry + WET_GAIN*y) >>> 15).
- Width rules:
  - Products are 32-bit signed.
  - Allpass sums are formed at 17 bits; the mix sum at 33 bits.
  - `>>>` is an arithmetic shift that floors.
  - sat16 clamps to [-32768, 32767].
- FSM states: CLEAR, IDLE, READ, CALC1, CALC2, MIX.
  - CLEAR: writes 0 to each RAM address, one per cycle, DELAY cycles total; then goes to IDLE with ptr=0.
  - IDLE: `ready`=1. On `in_valid`, registers din/dry_in and issues the read of RAM[ptr], then goes to READ.
  - READ: RAM data is captured into `buf`; go to CALC1.
  - CALC1: compute and register v; go to CALC2.
  - CALC2: write v to RAM[ptr]; compute and register y; advance ptr; go to MIX.
  - MIX: register dout and set `out_valid`; return to IDLE.
- `in_valid` while not IDLE (including CLEAR): the sample is dropped, `overrun` is set to 1, and processing of the current sample is unaffected.

## Timing
- Reset values: state=CLEAR, ptr=0, `ready`=0, `dout`=0, `out_valid`=0, `overrun`=0.
- Reset has priority over everything. Asserting it mid-sample aborts the sample, produces no `out_valid`, and restarts CLEAR.
- After reset deasserts, `ready` rises after exactly DELAY clear cycles.
- Sample accepted at edge E0 -> `out_valid`=1 during the cycle after edge E4. Latency is 4 cycles.
- `ready` is high again in that same cycle, so a strobe there is accepted. Maximum throughput is 1 sample per 5 clocks, far above the audio sample rate.
- `out_valid` is high for exactly one cycle per accepted sample. `dout` holds its value between pulses.
- Pointer wrap: after the sample processed at ptr=DELAY-1, the next sample uses ptr=0.

## Test plan
- Reset/clear: with DELAY=4, release reset -> `ready`=0 for 4 cycles then 1; `dout`=0, `out_valid`=0, `overrun`=0 throughout.
- Impulse (DELAY=4, GAIN=16384, DRY_GAIN=0, WET_GAIN=32767): din sequence 16384,0,0,0,0 ->
  - `dout` = -8192, 0, 0, 0, 12287;
  - each `out_valid` arrives exactly 4 cycles after its strobe.
- Saturation (GAIN=32767, DRY_GAIN=WET_GAIN=32767): first sample din=-32768, dry_in=32767 -> y=32767, mix clamps, `dout`=32767. Negative mirror case -> -32768.
- Overrun: strobe at E0, second strobe at E2 ->
  - exactly one `out_valid`, for the E0 sample only;
  - `overrun`=1 and stays 1 until reset.
- Wrap: DELAY=4, feed 9 samples -> the 9th output uses v written by sample 5 (ptr cycle 0,1,2,3,0,...); compare against a golden model.
- Mid-operation reset: assert reset in CALC1 -> no `out_valid`; CLEAR reruns; the next impulse response matches the post-reset impulse test.
